// File: rtl/path_stack_decoder.sv
// ---------------------------------------------------------------------------
// path_stack_decoder
//
// Records explorer moves as {prevLoc, dir} entries on a LIFO and can replay
// the recorded directions, oldest first, over a valid/ready stream.
//
// Direction encoding (same as the explorer's move encoding):
//   00 y-1   01 x+1   10 x-1   11 y+1
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   clr             synchronous clear: empties the stack, returns to REC
//   push            record step prevLoc -> newLoc ({x[7:4], y[3:0]})
//   pop             backtrack one step; popValid/backLoc/backDir next cycle
//   replayStart     begin playback (REC only)
//   dirOut/outValid/outReady   playback stream
//   replayDone      one-cycle pulse after the final transfer
//   depth/full/empty           occupancy
//   err             one-cycle pulse after a rejected request
//
// Build option
//   WRAP_MOVES_EN   when defined, 4-bit modular steps (15->0, 0->15) are
//                   legal, matching the explorer's adder arithmetic.
// ---------------------------------------------------------------------------
module path_stack_decoder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [7:0]    prevLoc,
    input  logic [7:0]    newLoc,
    input  logic          pop,
    output logic          popValid,
    output logic [7:0]    backLoc,
    output logic [1:0]    backDir,
    input  logic          replayStart,
    output logic [1:0]    dirOut,
    output logic          outValid,
    input  logic          outReady,
    output logic          replayDone,
    output logic [AW:0]   depth,
    output logic          full,
    output logic          empty,
    output logic          err
);

    typedef enum logic [1:0] {REC, RPL, FIN} state_t;

    typedef struct packed {
        logic [7:0] loc;
        logic [1:0] dir;
    } entry_t;

    entry_t        mem [DEPTH];
    state_t        state, state_nx;
    logic [AW-1:0] idx, idx_nx;
    logic [AW-1:0] top_idx;
    logic          last_xfer;
    logic          do_push, do_pop, err_nx;

    // ---------------------------------------------------------------------
    // Step decode
    // ---------------------------------------------------------------------
    logic [3:0] xp, yp, xn, yn;
    logic       xinc, xdec, yinc, ydec;
    logic       step_ok;
    logic [1:0] step_dir;

    always_comb begin
        xp = prevLoc[7:4];
        yp = prevLoc[3:0];
        xn = newLoc[7:4];
        yn = newLoc[3:0];
`ifdef WRAP_MOVES_EN
        // 4-bit compare: the +/-1 wraps exactly like the explorer's adder
        xinc = (xn == xp + 4'd1);
        xdec = (xn == xp - 4'd1);
        yinc = (yn == yp + 4'd1);
        ydec = (yn == yp - 4'd1);
`else
        // Edge coordinates cannot step outward; a wrapped pair is illegal
        xinc = (xp != 4'hF) && (xn == xp + 4'd1);
        xdec = (xp != 4'h0) && (xn == xp - 4'd1);
        yinc = (yp != 4'hF) && (yn == yp + 4'd1);
        ydec = (yp != 4'h0) && (yn == yp - 4'd1);
`endif
        step_ok  = 1'b1;
        step_dir = 2'b00;
        if (xp == xn && yinc)      step_dir = 2'b11;
        else if (xp == xn && ydec) step_dir = 2'b00;
        else if (yp == yn && xinc) step_dir = 2'b01;
        else if (yp == yn && xdec) step_dir = 2'b10;
        else                       step_ok  = 1'b0;
    end

    assign full    = (depth == (AW+1)'(DEPTH));
    assign empty   = (depth == '0);
    assign top_idx = AW'(depth - 1'b1);
    // Replay index points at the final stored entry
    assign last_xfer = (({1'b0, idx} + 1'b1) == depth);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REC;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state, stack requests and stream outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        err_nx     = 1'b0;
        outValid   = 1'b0;
        dirOut     = 2'b00;
        replayDone = 1'b0;

        case (state)
            REC: begin
                if (push && pop) begin
                    err_nx = 1'b1;
                end else if (push) begin
                    if (full || !step_ok) err_nx  = 1'b1;
                    else                  do_push = 1'b1;
                end else if (pop) begin
                    if (empty) err_nx = 1'b1;
                    else       do_pop = 1'b1;
                end
                if (replayStart) begin
                    if (empty) begin
                        state_nx = FIN;
                    end else begin
                        idx_nx   = '0;
                        state_nx = RPL;
                    end
                end
            end
            RPL: begin
                outValid = 1'b1;
                dirOut   = mem[idx].dir;
                if (push || pop) err_nx = 1'b1;
                if (outReady) begin
                    if (last_xfer) state_nx = FIN;
                    else           idx_nx   = idx + 1'b1;
                end
            end
            FIN: begin
                replayDone = 1'b1;
                state_nx   = REC;
                if (push || pop) err_nx = 1'b1;
            end
            default: state_nx = REC;
        endcase

        // clr wins over any request in flight and never flags err
        if (clr) begin
            state_nx = REC;
            idx_nx   = '0;
            do_push  = 1'b0;
            do_pop   = 1'b0;
            err_nx   = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Stack storage (no reset needed: depth gates every read)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_push) mem[depth[AW-1:0]] <= '{loc: prevLoc, dir: step_dir};
    end

    // ---------------------------------------------------------------------
    // Occupancy, pop response and error pulse
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            depth    <= '0;
            popValid <= 1'b0;
            backLoc  <= 8'h00;
            backDir  <= 2'b00;
            err      <= 1'b0;
        end else if (clr) begin
            depth    <= '0;
            popValid <= 1'b0;
            err      <= 1'b0;
        end else begin
            err      <= err_nx;
            popValid <= do_pop;
            if (do_push) depth <= depth + 1'b1;
            if (do_pop) begin
                depth   <= depth - 1'b1;
                backLoc <= mem[top_idx].loc;
                // inverse move: 00<->11, 01<->10
                backDir <= ~mem[top_idx].dir;
            end
        end
    end

endmodule
